// File: rtl/nav_spi_arbiter_pkg.sv
// rtl/nav_spi_arbiter_pkg.sv - shared FSM encoding, requester indices and timing defaults
package nav_spi_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_XFER   = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam int REQ_AG  = 0;
  localparam int REQ_MAG = 1;
  localparam int REQ_ALT = 2;

  localparam int DEFAULT_GAP_CYCLES = 50;
  localparam int DEFAULT_START_TO   = 255;

endpackage

// File: rtl/nav_spi_arbiter_rr_pick.sv
// rtl/nav_spi_arbiter_rr_pick.sv - round-robin pick of the first request at or after ptr
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  logic found;

  // Outer loop walks distance from ptr, so the nearest requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          idx    = PW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/nav_spi_arbiter.sv
// rtl/nav_spi_arbiter.sv - round-robin arbiter sharing one SPI master between nav sensors
module nav_spi_arbiter
  import nav_spi_arbiter_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int START_TO   = DEFAULT_START_TO
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [16*NREQ-1:0] req_tx,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [15:0]        rx_data,
  output logic               spi_start,
  output logic [15:0]        spi_tx,
  input  logic [15:0]        spi_rx,
  input  logic               spi_busy,
  input  logic               spi_cs,
  output logic [NREQ-1:0]    cs_n
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_d;
  logic [NREQ-1:0] gnt_d, err_d, pick_gnt;
  logic [PW-1:0]   rr_ptr, ptr_d, idx_q, idx_d, pick_idx;
  logic [15:0]     cnt, cnt_d, tx_d, rx_d, tx_sel;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    tx_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) tx_sel = req_tx[16*i +: 16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      gnt     <= '0;
      err     <= '0;
      spi_tx  <= '0;
      rx_data <= '0;
      rr_ptr  <= '0;
      idx_q   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      err     <= err_d;
      spi_tx  <= tx_d;
      rx_data <= rx_d;
      rr_ptr  <= ptr_d;
      idx_q   <= idx_d;
      cnt     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    err_d   = '0;
    tx_d    = spi_tx;
    rx_d    = rx_data;
    ptr_d   = rr_ptr;
    idx_d   = idx_q;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          tx_d    = tx_sel;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (spi_busy) begin
          state_d = S_XFER;
        end else if (cnt == 16'(START_TO - 1)) begin
          // Pointer is left alone so the failed requester is retried first.
          err_d   = gnt;
          gnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_XFER: begin
        if (!spi_busy) begin
          rx_d    = spi_rx;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == 16'(GAP_CYCLES - 1)) state_d = S_FINISH;
        else                            cnt_d   = cnt + 16'd1;
      end
      S_FINISH: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset drops them immediately.
  assign spi_start = (state == S_START);
  assign done      = (state == S_FINISH) ? gnt : '0;

  always_comb begin
    cs_n = '1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) cs_n[i] = spi_cs;
    end
  end

endmodule

// File: tb/tb_nav_spi_arbiter.sv
// tb/tb_nav_spi_arbiter.sv - directed self-checking bench for nav_spi_arbiter
module tb_nav_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [47:0] req_tx;
  logic [2:0]  gnt, done, err, cs_n;
  logic [15:0] rx_data, spi_tx, spi_rx;
  logic        spi_start, spi_busy, spi_cs;

  int n_tests = 0;
  int n_fail  = 0;

  nav_spi_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_tx    (req_tx),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rx_data   (rx_data),
    .spi_start (spi_start),
    .spi_tx    (spi_tx),
    .spi_rx    (spi_rx),
    .spi_busy  (spi_busy),
    .spi_cs    (spi_cs),
    .cs_n      (cs_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic run_xfer(input logic [2:0] exp_gnt, input logic [15:0] exp_tx,
                          input logic [15:0] rxw, input logic [2:0] drop_mask,
                          input bit poke_tx, input bit keep_req);
    int n;
    int lat;
    int errs;
    n = 0;
    while (!spi_start && n < 10) begin tick; n++; end
    check_eq("start_seen", {31'd0, spi_start}, 32'd1);
    check_eq("grant", {29'd0, gnt}, {29'd0, exp_gnt});
    check_eq("spi_tx", {16'd0, spi_tx}, {16'd0, exp_tx});
    spi_busy = 1'b1;
    tick;
    check_eq("start_drop", {31'd0, spi_start}, 32'd0);
    req    = req & ~drop_mask;
    spi_cs = 1'b0;
    tick;
    check_eq("cs_n_xfer", {29'd0, cs_n}, {29'd0, ~exp_gnt});
    spi_rx   = rxw;
    spi_busy = 1'b0;
    spi_cs   = 1'b1;
    lat  = 0;
    errs = 0;
    while (done == 3'b000 && lat < 200) begin
      tick;
      lat++;
      if (err != 3'b000) errs++;
      if (poke_tx && lat == 5) req_tx[15:0] = 16'hFFFF;
    end
    check_eq("done_latency", lat, 32'd51);
    check_eq("done", {29'd0, done}, {29'd0, exp_gnt});
    check_eq("rx_data", {16'd0, rx_data}, {16'd0, rxw});
    check_eq("no_err", errs, 32'd0);
    if (poke_tx) check_eq("tx_stable", {16'd0, spi_tx}, {16'd0, exp_tx});
    if (!keep_req) req = 3'b000;
    tick;
    check_eq("idle_gap", {29'd0, gnt}, 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    rst_n    = 1'b0;
    req      = 3'b000;
    req_tx   = '0;
    spi_rx   = '0;
    spi_busy = 1'b0;
    spi_cs   = 1'b1;
    repeat (3) tick;
    check_eq("rst_gnt", {29'd0, gnt}, 32'd0);
    check_eq("rst_done_err", {26'd0, done, err}, 32'd0);
    check_eq("rst_start", {31'd0, spi_start}, 32'd0);
    check_eq("rst_tx_rx", {spi_tx, rx_data}, 32'd0);
    check_eq("rst_cs_n", {29'd0, cs_n}, 32'd7);
    rst_n = 1'b1;
    tick;

    // Single request from the accel/gyro.
    req_tx[15:0] = 16'hA800;
    req = 3'b001;
    run_xfer(3'b001, 16'hA800, 16'h00C3, 3'b000, 1'b0, 1'b0);

    // Re-reset so the pointer starts at 0, then full contention.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    req_tx = {16'h3333, 16'h2222, 16'h1111};
    req    = 3'b111;
    run_xfer(3'b001, 16'h1111, 16'h0A01, 3'b000, 1'b0, 1'b1);
    run_xfer(3'b010, 16'h2222, 16'h0A02, 3'b000, 1'b0, 1'b1);
    run_xfer(3'b100, 16'h3333, 16'h0A03, 3'b000, 1'b0, 1'b1);
    run_xfer(3'b001, 16'h1111, 16'h0A04, 3'b000, 1'b0, 1'b0);

    // Magnetometer timeout: busy never rises.
    req = 3'b010;
    n = 0;
    while (!spi_start && n < 10) begin tick; n++; end
    check_eq("to_start", {31'd0, spi_start}, 32'd1);
    n = 0;
    dones = 0;
    while (err == 3'b000 && n < 400) begin
      tick;
      n++;
      if (done != 3'b000) dones++;
    end
    check_eq("to_latency", n, 32'd255);
    check_eq("to_err", {29'd0, err}, 32'd2);
    check_eq("to_no_done", dones, 32'd0);
    check_eq("to_gnt_clear", {29'd0, gnt}, 32'd0);
    req = 3'b011;
    run_xfer(3'b010, 16'h2222, 16'h0B01, 3'b000, 1'b0, 1'b0);

    // Altimeter drops req mid-transfer.
    req = 3'b100;
    run_xfer(3'b100, 16'h3333, 16'h0C01, 3'b100, 1'b0, 1'b0);

    // Command word changed during the gap must not reach spi_tx.
    req_tx[15:0] = 16'h5A5A;
    req = 3'b001;
    run_xfer(3'b001, 16'h5A5A, 16'h0D01, 3'b000, 1'b1, 1'b0);

    // Short asynchronous reset pulse mid-transfer.
    req = 3'b100;
    n = 0;
    while (!spi_start && n < 10) begin tick; n++; end
    spi_busy = 1'b1;
    tick;
    spi_cs = 1'b0;
    tick;
    check_eq("ar_cs_n_low", {29'd0, cs_n}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_gnt", {29'd0, gnt}, 32'd0);
    check_eq("ar_start", {31'd0, spi_start}, 32'd0);
    check_eq("ar_cs_n", {29'd0, cs_n}, 32'd7);
    #1 rst_n = 1'b1;
    req      = 3'b000;
    spi_busy = 1'b0;
    spi_cs   = 1'b1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (done != 3'b000) dones++;
    end
    check_eq("ar_no_done", dones, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
